// File: rtl/safe_mult_pipe.sv
// Saturating signed fixed-point multiplier, Q(A)*Q(B)->Q(Q); optional overflow counter via SAFE_MULT_OVF_CNT_EN.
// Latency PIPE_STAGES cycles (1..4): product in stage 1, align/round/saturate in the last stage.
// Global stall: every stage holds while out_valid && !out_ready; in_ready mirrors that.
module safe_mult_pipe #(
    parameter int A_WIDTH     = 16,
    parameter int A_FRAC      = 8,
    parameter int B_WIDTH     = 16,
    parameter int B_FRAC      = 8,
    parameter int Q_WIDTH     = 16,
    parameter int Q_FRAC      = 8,
    parameter int PIPE_STAGES = 2,
    parameter int ROUND_MODE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] Q,
    output logic               overflow
`ifdef SAFE_MULT_OVF_CNT_EN
    ,
    output logic [15:0]        ovf_cnt,
    input  logic               cnt_clr
`endif
);

    localparam int PW  = A_WIDTH + B_WIDTH;
    localparam int S   = A_FRAC + B_FRAC - Q_FRAC;
    localparam int LSH = (S < 0) ? -S : 0;
    localparam int AW0 = PW + 1 + LSH;
    localparam int AW  = (AW0 > Q_WIDTH + 1) ? AW0 : Q_WIDTH + 1;
    localparam int D   = PIPE_STAGES - 1;

    localparam logic signed [AW-1:0] Q_MAX = {{(AW-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] Q_MIN = {{(AW-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                 vld;
        logic signed [PW-1:0] prod;
    } prod_stage_t;

    logic                 advance;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] sat_in;
    logic                 sat_in_vld;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] aligned;
    logic [Q_WIDTH-1:0]   q_nxt;
    logic                 ovf_nxt;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operands widened to the full product width so the multiply is exact.
    assign a_ext  = PW'($signed(A));
    assign b_ext  = PW'($signed(B));
    assign prod_c = a_ext * b_ext;

    generate
        if (D == 0) begin : g_no_dly
            assign sat_in     = prod_c;
            assign sat_in_vld = in_valid;
        end else begin : g_dly
            prod_stage_t p_stg [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        p_stg[i] <= '0;
                    end
                end else if (advance) begin
                    p_stg[0].vld <= in_valid;
                    if (in_valid) begin
                        p_stg[0].prod <= prod_c;
                    end
                    for (int i = 1; i < D; i++) begin
                        p_stg[i].vld <= p_stg[i-1].vld;
                        if (p_stg[i-1].vld) begin
                            p_stg[i].prod <= p_stg[i-1].prod;
                        end
                    end
                end
            end

            assign sat_in     = p_stg[D-1].prod;
            assign sat_in_vld = p_stg[D-1].vld;
        end
    endgenerate

    // One guard bit above the product absorbs a rounding carry before the range check.
    assign ext = AW'(sat_in);

    generate
        if (S > 0) begin : g_rshift
            localparam logic signed [AW-1:0] RND_ADD =
                (ROUND_MODE == 1) ? (AW'(1) << (S - 1)) : '0;
            logic signed [AW-1:0] rnd;
            assign rnd     = ext + RND_ADD;
            assign aligned = rnd >>> S;
        end else begin : g_lshift
            assign aligned = ext <<< LSH;
        end
    endgenerate

    always_comb begin
        q_nxt   = aligned[Q_WIDTH-1:0];
        ovf_nxt = 1'b0;
        if (aligned > Q_MAX) begin
            q_nxt   = Q_MAX[Q_WIDTH-1:0];
            ovf_nxt = 1'b1;
        end else if (aligned < Q_MIN) begin
            q_nxt   = Q_MIN[Q_WIDTH-1:0];
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Q         <= '0;
            overflow  <= 1'b0;
        end else if (advance) begin
            out_valid <= sat_in_vld;
            if (sat_in_vld) begin
                Q        <= q_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

`ifdef SAFE_MULT_OVF_CNT_EN
    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && overflow && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`else
    // Without the counter the datapath above is the whole block.
`endif

endmodule
